// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: two-requester handshake and memory/IO bus signals of the bus arbiter
interface bus_arbiter_if #(parameter int WIDTH = 16);
  logic req0, we0, ack0, req1, we1, ack1;
  logic busy, bus_read_strobe, bus_write_strobe;
  logic [WIDTH-1:0] addr0, wdata0, addr1, wdata1, rdata;
  logic [WIDTH-1:0] bus_addr, bus_wdata, bus_rdata;
  modport slave (
    input req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_rdata,
    output ack0, ack1, rdata, busy, bus_addr, bus_wdata, bus_read_strobe, bus_write_strobe
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_rdata,
    input ack0, ack1, rdata, busy, bus_addr, bus_wdata, bus_read_strobe, bus_write_strobe
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter granting two requesters a strobed memory/IO bus
module bus_arbiter #(
  parameter int WIDTH = 16,
  parameter int STROBE_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, STROBE, ACK} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic last_q, last_d, win_q, win_d, we_q, we_d, win;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  always_comb begin
    win = (bus.req0 && bus.req1) ? !last_q : bus.req1;
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    win_d = win_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.req0 || bus.req1) begin
        state_d = ADDR;
        last_d = win;
        win_d = win;
        we_d = win ? bus.we1 : bus.we0;
        addr_d = win ? bus.addr1 : bus.addr0;
        wdata_d = win ? bus.wdata1 : bus.wdata0;
      end
      ADDR: begin
        state_d = STROBE;
        cnt_d = 4'(STROBE_CYCLES - 1);
      end
      STROBE: if (cnt_q == 4'd0) begin
        state_d = ACK;
        rdata_d = we_q ? rdata_q : bus.bus_rdata;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      win_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      win_q <= win_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.ack0 = (state_q == ACK) && !win_q;
  assign bus.ack1 = (state_q == ACK) && win_q;
  assign bus.busy = state_q != IDLE;
  assign bus.bus_read_strobe = (state_q == STROBE) && !we_q;
  assign bus.bus_write_strobe = (state_q == STROBE) && we_q;
  assign bus.bus_addr = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed table and sequence checks of bus_arbiter with 1- and 3-cycle strobes
module tb_bus_arbiter;
  logic clk, reset;
  int checks, errors;
  bus_arbiter_if #(.WIDTH(16)) i1();
  bus_arbiter_if #(.WIDTH(16)) i3();
  bus_arbiter #(.WIDTH(16), .STROBE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));
  bus_arbiter #(.WIDTH(16), .STROBE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(i3.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct packed {
    logic r0, w0;
    logic [15:0] a0, d0;
    logic r1, w1;
    logic [15:0] a1, d1, brd;
    logic e_ack0, e_ack1, e_busy, e_rs, e_ws;
    logic [15:0] e_addr, e_wdata, e_rdata;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic obs(int sel, string nm, logic a0, logic a1, logic b, logic rs, logic ws,
                     logic [15:0] ad, logic [15:0] wd, logic [15:0] rd);
    @(negedge clk);
    chk({nm, ".ack0"}, 32'(sel ? i3.ack0 : i1.ack0), 32'(a0));
    chk({nm, ".ack1"}, 32'(sel ? i3.ack1 : i1.ack1), 32'(a1));
    chk({nm, ".busy"}, 32'(sel ? i3.busy : i1.busy), 32'(b));
    chk({nm, ".rd_strobe"}, 32'(sel ? i3.bus_read_strobe : i1.bus_read_strobe), 32'(rs));
    chk({nm, ".wr_strobe"}, 32'(sel ? i3.bus_write_strobe : i1.bus_write_strobe), 32'(ws));
    chk({nm, ".bus_addr"}, 32'(sel ? i3.bus_addr : i1.bus_addr), 32'(ad));
    chk({nm, ".bus_wdata"}, 32'(sel ? i3.bus_wdata : i1.bus_wdata), 32'(wd));
    chk({nm, ".rdata"}, 32'(sel ? i3.rdata : i1.rdata), 32'(rd));
    @(posedge clk);
    #1;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    {i1.req0, i1.we0, i1.addr0, i1.wdata0, i1.req1, i1.we1, i1.addr1, i1.wdata1, i1.bus_rdata} = '0;
    {i3.req0, i3.we0, i3.addr0, i3.wdata0, i3.req1, i3.we1, i3.addr1, i3.wdata1, i3.bus_rdata} = '0;
    tbl[0]  = '{1'b1, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hAAAA, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 16'hAAAA, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hAAAA, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'hAAAA, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b0, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 16'h0100, 16'hAAAA, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h5555};
    tbl[8]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h5555};
    tbl[9]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5555};
    tbl[10] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5555};
    tbl[11] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
    tbl[12] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
    #2;
    chk("reset.busy", 32'(i1.busy), 32'd0);
    chk("reset.acks", 32'({i1.ack0, i1.ack1}), 32'd0);
    chk("reset.strobes", 32'({i1.bus_read_strobe, i1.bus_write_strobe}), 32'd0);
    chk("reset.bus_addr", 32'(i1.bus_addr), 32'd0);
    chk("reset.rdata", 32'(i1.rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 13; k++) begin
      {i1.req0, i1.we0, i1.addr0, i1.wdata0} = {tbl[k].r0, tbl[k].w0, tbl[k].a0, tbl[k].d0};
      {i1.req1, i1.we1, i1.addr1, i1.wdata1} = {tbl[k].r1, tbl[k].w1, tbl[k].a1, tbl[k].d1};
      i1.bus_rdata = tbl[k].brd;
      obs(0, $sformatf("row%0d", k), tbl[k].e_ack0, tbl[k].e_ack1, tbl[k].e_busy, tbl[k].e_rs,
          tbl[k].e_ws, tbl[k].e_addr, tbl[k].e_wdata, tbl[k].e_rdata);
    end
    i1.req0 = 1'b1; i1.we0 = 1'b0; i1.addr0 = 16'h0300; i1.bus_rdata = 16'h1111;
    obs(0, "mid_idle", 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'hBEEF);
    obs(0, "mid_addr", 0, 0, 1, 0, 0, 16'h0300, 16'h0000, 16'hBEEF);
    i1.addr0 = 16'h0444; i1.req0 = 1'b0;
    obs(0, "mid_strobe", 0, 0, 1, 1, 0, 16'h0300, 16'h0000, 16'hBEEF);
    obs(0, "mid_ack", 1, 0, 1, 0, 0, 16'h0300, 16'h0000, 16'h1111);
    obs(0, "mid_after", 0, 0, 0, 0, 0, 16'h0300, 16'h0000, 16'h1111);
    i1.req0 = 1'b1; i1.addr0 = 16'h0500; i1.bus_rdata = 16'h2222;
    obs(0, "b2b_idle", 0, 0, 0, 0, 0, 16'h0300, 16'h0000, 16'h1111);
    obs(0, "b2b_addr", 0, 0, 1, 0, 0, 16'h0500, 16'h0000, 16'h1111);
    obs(0, "b2b_strobe", 0, 0, 1, 1, 0, 16'h0500, 16'h0000, 16'h1111);
    i1.addr0 = 16'h0600;
    obs(0, "b2b_ack", 1, 0, 1, 0, 0, 16'h0500, 16'h0000, 16'h2222);
    i1.bus_rdata = 16'h3333;
    obs(0, "b2b_gap", 0, 0, 0, 0, 0, 16'h0500, 16'h0000, 16'h2222);
    obs(0, "b2b_addr2", 0, 0, 1, 0, 0, 16'h0600, 16'h0000, 16'h2222);
    obs(0, "b2b_strobe2", 0, 0, 1, 1, 0, 16'h0600, 16'h0000, 16'h2222);
    obs(0, "b2b_ack2", 1, 0, 1, 0, 0, 16'h0600, 16'h0000, 16'h3333);
    i1.req0 = 1'b0;
    obs(0, "b2b_done", 0, 0, 0, 0, 0, 16'h0600, 16'h0000, 16'h3333);
    i1.req1 = 1'b1; i1.we1 = 1'b0; i1.addr1 = 16'h0700; i1.wdata1 = 16'h0000; i1.bus_rdata = 16'h4444;
    obs(0, "rst_idle", 0, 0, 0, 0, 0, 16'h0600, 16'h0000, 16'h3333);
    obs(0, "rst_addr", 0, 0, 1, 0, 0, 16'h0700, 16'h0000, 16'h3333);
    #1;
    chk("rst_pre.rd_strobe", 32'(i1.bus_read_strobe), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async.rd_strobe", 32'(i1.bus_read_strobe), 32'd0);
    chk("rst_async.busy", 32'(i1.busy), 32'd0);
    chk("rst_async.ack1", 32'(i1.ack1), 32'd0);
    chk("rst_async.bus_addr", 32'(i1.bus_addr), 32'd0);
    chk("rst_async.rdata", 32'(i1.rdata), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held.ack1", 32'(i1.ack1), 32'd0);
    chk("rst_held.busy", 32'(i1.busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    obs(0, "rel_idle", 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    obs(0, "rel_addr", 0, 0, 1, 0, 0, 16'h0700, 16'h0000, 16'h0000);
    obs(0, "rel_strobe", 0, 0, 1, 1, 0, 16'h0700, 16'h0000, 16'h0000);
    obs(0, "rel_ack", 0, 1, 1, 0, 0, 16'h0700, 16'h0000, 16'h4444);
    i1.req1 = 1'b0;
    obs(0, "rel_done", 0, 0, 0, 0, 0, 16'h0700, 16'h0000, 16'h4444);
    i3.req1 = 1'b1; i3.we1 = 1'b1; i3.addr1 = 16'h8001; i3.wdata1 = 16'h1234; i3.bus_rdata = 16'h7777;
    obs(1, "w3_idle", 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    obs(1, "w3_addr", 0, 0, 1, 0, 0, 16'h8001, 16'h1234, 16'h0000);
    i3.addr1 = 16'hFFFF; i3.wdata1 = 16'h0000;
    obs(1, "w3_strobe1", 0, 0, 1, 0, 1, 16'h8001, 16'h1234, 16'h0000);
    obs(1, "w3_strobe2", 0, 0, 1, 0, 1, 16'h8001, 16'h1234, 16'h0000);
    obs(1, "w3_strobe3", 0, 0, 1, 0, 1, 16'h8001, 16'h1234, 16'h0000);
    obs(1, "w3_ack", 0, 1, 1, 0, 0, 16'h8001, 16'h1234, 16'h0000);
    i3.req1 = 1'b0;
    obs(1, "w3_done", 0, 0, 0, 0, 0, 16'h8001, 16'h1234, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
